// File: rtl/state_sequencer_pkg.sv
// Shared control package: state numbering and widths used by the sequencer and the next-state decoder,
// plus register-list helpers.
package state_sequencer_pkg;

    localparam int CTRL_STATE_W     = 10;
    localparam int ST_RESET         = 0;
    localparam int ST_FAULT         = 1;
    localparam int CTRL_RESET_STATE = ST_RESET;
    localparam int CTRL_FAULT_STATE = ST_FAULT;

    localparam int LIST_W   = 16;
    localparam int CNT_W    = 5;
    localparam int REGNUM_W = 4;
    localparam int WAIT_W   = 8;

    typedef enum logic [1:0] {
        SEQ_ADVANCE,
        SEQ_HOLD,
        SEQ_FAULT
    } seq_action_e;

    function automatic logic [CNT_W-1:0] popcount16(input logic [LIST_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LIST_W; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Scans downwards so the last hit is the lowest set bit; an empty mask yields 0.
    function automatic logic [REGNUM_W-1:0] lowest_set16(input logic [LIST_W-1:0] v);
        logic [REGNUM_W-1:0] idx;
        idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (v[i]) idx = REGNUM_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/reglist_iter.sv
// LDM/STM register-list iterator: holds the remaining register mask and its count,
// and presents the lowest remaining register number.
module reglist_iter
    import state_sequencer_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [LIST_W-1:0]   mask_i,
    output logic [REGNUM_W-1:0] reg_num_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                last_o,
    output logic                empty_o
);

    logic [LIST_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Load wins over step; stepping an empty list leaves it empty.
    always_comb begin
        mask_d  = mask_q;
        count_d = count_q;
        if (load_i) begin
            mask_d  = mask_i;
            count_d = popcount16(mask_i);
        end else if (step_i && (count_q != '0)) begin
            mask_d  = mask_q & (mask_q - LIST_W'(1));
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    assign reg_num_o = lowest_set16(mask_q);
    assign count_o   = count_q;
    assign last_o    = (count_q == CNT_W'(1));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/state_sequencer.sv
// Control-state register with memory-wait hold and MOC timeout fault, alongside
// the LDM/STM register-list iterator.
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int STATE_W     = CTRL_STATE_W,
    parameter int RESET_STATE = CTRL_RESET_STATE,
    parameter int FAULT_STATE = CTRL_FAULT_STATE,
    parameter int MOC_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] next_state,
    input  logic               mem_wait,
    input  logic               moc,
    input  logic               list_load,
    input  logic               list_step,
    input  logic [31:0]        ir,
    output logic [STATE_W-1:0] state,
    output logic [3:0]         reg_num,
    output logic [4:0]         list_count,
    output logic               list_last,
    output logic               list_empty,
    output logic               mem_fault
);

    localparam logic [STATE_W-1:0] RESET_ST     = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FAULT_ST     = STATE_W'(FAULT_STATE);
    localparam logic [WAIT_W-1:0]  TIMEOUT_LAST = WAIT_W'(MOC_TIMEOUT - 1);

    seq_action_e        action;
    logic [STATE_W-1:0] state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               fault_q, fault_d;

    // moc is checked first, so a completion in the timeout cycle beats the fault.
    always_comb begin
        action  = SEQ_ADVANCE;
        state_d = next_state;
        wait_d  = '0;
        fault_d = 1'b0;
        if (mem_wait && !moc) begin
            action = (wait_q == TIMEOUT_LAST) ? SEQ_FAULT : SEQ_HOLD;
        end
        case (action)
            SEQ_HOLD: begin
                state_d = state_q;
                wait_d  = wait_q + WAIT_W'(1);
            end
            SEQ_FAULT: begin
                state_d = FAULT_ST;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_ST;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    assign state     = state_q;
    assign mem_fault = fault_q;

    logic unused_ir_hi;
    assign unused_ir_hi = ^ir[31:16];

    reglist_iter u_reglist_iter (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (list_load),
        .step_i    (list_step),
        .mask_i    (ir[15:0]),
        .reg_num_o (reg_num),
        .count_o   (list_count),
        .last_o    (list_last),
        .empty_o   (list_empty)
    );

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: a vector table for reset, wait/advance and list
// iteration, then hand-written timeout and mid-operation reset sequences.
module tb_state_sequencer;

    logic        clk;
    logic        reset;
    logic [9:0]  next_state;
    logic        mem_wait;
    logic        moc;
    logic        list_load;
    logic        list_step;
    logic [31:0] ir;
    logic [9:0]  state;
    logic [3:0]  reg_num;
    logic [4:0]  list_count;
    logic        list_last;
    logic        list_empty;
    logic        mem_fault;

    int n_checks = 0;
    int n_fail   = 0;

    state_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .next_state (next_state),
        .mem_wait   (mem_wait),
        .moc        (moc),
        .list_load  (list_load),
        .list_step  (list_step),
        .ir         (ir),
        .state      (state),
        .reg_num    (reg_num),
        .list_count (list_count),
        .list_last  (list_last),
        .list_empty (list_empty),
        .mem_fault  (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [9:0]  ns;
        logic        mw;
        logic        moc;
        logic        ld;
        logic        st;
        logic [15:0] ir;
        logic [9:0]  e_state;
        logic [4:0]  e_cnt;
        logic [3:0]  e_reg;
        logic        e_fault;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check every output just after the edge.
    task automatic cycle(input string tag, input logic rst, input logic [9:0] ns,
                         input logic mw, input logic mc, input logic ld, input logic st,
                         input logic [15:0] irv, input logic [9:0] e_state,
                         input logic [4:0] e_cnt, input logic [3:0] e_reg, input logic e_fault);
        reset      = rst;
        next_state = ns;
        mem_wait   = mw;
        moc        = mc;
        list_load  = ld;
        list_step  = st;
        ir         = {16'hA5A5, irv};
        @(posedge clk);
        #1;
        check({tag, ".state"},      32'(state),      32'(e_state));
        check({tag, ".fault"},      32'(mem_fault),  32'(e_fault));
        check({tag, ".count"},      32'(list_count), 32'(e_cnt));
        check({tag, ".reg_num"},    32'(reg_num),    32'(e_reg));
        check({tag, ".list_last"},  32'(list_last),  32'(e_cnt == 5'd1));
        check({tag, ".list_empty"}, 32'(list_empty), 32'(e_cnt == 5'd0));
    endtask

    initial begin
        vecs[0] = '{1'b1, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 10'd0, 5'd0,  4'd0,  1'b0};
        vecs[1] = '{1'b1, 10'd5, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 10'd0, 5'd0,  4'd0,  1'b0};
        vecs[2] = '{1'b0, 10'd5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8005, 10'd5, 5'd3,  4'd0,  1'b0};
        vecs[3] = '{1'b0, 10'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 10'd3, 5'd2,  4'd2,  1'b0};
        vecs[4] = '{1'b0, 10'd9, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 10'd3, 5'd1,  4'd15, 1'b0};
        vecs[5] = '{1'b0, 10'd9, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 10'd3, 5'd0,  4'd0,  1'b0};
        vecs[6] = '{1'b0, 10'd9, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 10'd3, 5'd0,  4'd0,  1'b0};
        vecs[7] = '{1'b0, 10'd9, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 10'd3, 5'd0,  4'd0,  1'b0};
        vecs[8] = '{1'b0, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 10'd4, 5'd16, 4'd0,  1'b0};

        reset = 1'b1; next_state = '0; mem_wait = 1'b0; moc = 1'b0;
        list_load = 1'b0; list_step = 1'b0; ir = '0;

        for (int i = 0; i < 9; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ns, vecs[i].mw, vecs[i].moc,
                  vecs[i].ld, vecs[i].st, vecs[i].ir, vecs[i].e_state, vecs[i].e_cnt,
                  vecs[i].e_reg, vecs[i].e_fault);
        end

        // Timeout: 16 wait cycles without moc lands in the fault state with a single pulse.
        cycle("to_pre", 1'b0, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 10'd3, 5'd16, 4'd0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cycle($sformatf("to_w%0d", i), 1'b0, 10'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
                  (i < 16) ? 10'd3 : 10'd1, 5'd16, 4'd0, (i == 16));
        end
        cycle("to_post", 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 10'd2, 5'd16, 4'd0, 1'b0);

        // moc arriving in the timeout cycle beats the fault.
        for (int i = 1; i <= 15; i++) begin
            cycle($sformatf("mp_w%0d", i), 1'b0, 10'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
                  10'd2, 5'd16, 4'd0, 1'b0);
        end
        cycle("mp_moc",  1'b0, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 10'd6, 5'd16, 4'd0, 1'b0);
        cycle("mp_post", 1'b0, 10'd6, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 10'd6, 5'd16, 4'd0, 1'b0);

        // Reset in the middle of a wait and a two-entry list iteration.
        cycle("rm_ld", 1'b0, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 10'd3, 5'd2, 4'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cycle($sformatf("rm_w%0d", i), 1'b0, 10'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
                  10'd3, 5'd2, 4'd0, 1'b0);
        end
        cycle("rm_rst", 1'b1, 10'd8, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 10'd0, 5'd0, 4'd0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cycle($sformatf("rm_a%0d", i), 1'b0, 10'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
                  (i < 16) ? 10'd0 : 10'd1, 5'd0, 4'd0, (i == 16));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 Parameter STATE_W, default 10, control-state width in bits.
REQ-002 Parameter RESET_STATE, default 0, state loaded on reset.
REQ-003 Parameter FAULT_STATE, default 1, state forced on memory timeout.
REQ-004 Parameter MOC_TIMEOUT, default 16, maximum wait cycles for MOC before fault; legal range 2..255.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, rising-edge clock for all state.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port next_state, input, STATE_W, next control state from the next-state decoder.
REQ-009 Port mem_wait, input, 1, the current state is a memory-wait state (driven by the control ROM).
REQ-010 Port moc, input, 1, memory operation complete.
REQ-011 Port list_load, input, 1, capture the LDM/STM register list from ir.
REQ-012 Port list_step, input, 1, consume the current register in the list.
REQ-013 Port ir, input, 32, instruction register; only ir[15:0] is used.
REQ-014 Port state, output, STATE_W, current control state fed back to the decoder.
REQ-015 Port reg_num, output, 4, index of the lowest set bit remaining in the list.
REQ-016 Port list_count, output, 5, number of registers remaining (0..16).
REQ-017 Port list_last, output, 1, high when list_count equals 1.
REQ-018 Port list_empty, output, 1, high when list_count equals 0.
REQ-019 Port mem_fault, output, 1, one-cycle pulse on MOC timeout.

Function
REQ-020 With mem_wait=0, state shall load next_state on every rising edge.
REQ-021 With mem_wait=1 and moc=0, state shall hold and the wait counter shall increment by 1 per cycle.
REQ-022 With mem_wait=1 and moc=1, state shall load next_state and the wait counter shall clear, whatever the count.
REQ-023 When the wait counter reaches MOC_TIMEOUT-1 with moc still 0, the next edge shall load FAULT_STATE, clear the counter, and pulse mem_fault high for exactly 1 cycle.
REQ-024 In the timeout cycle, moc=1 shall take priority over the fault.
REQ-025 The wait counter shall clear on any cycle with mem_wait=0.
REQ-026 list_load shall latch ir[15:0] into the list mask, and the registered list_count shall equal the popcount of the mask on the following cycle.
REQ-027 list_step shall clear the lowest set bit of the mask and decrement list_count, one register per cycle.
REQ-028 list_step with list_empty=1 shall have no effect, and list_count shall never wrap below 0.
REQ-029 When list_load and list_step are asserted in the same cycle, list_load shall win and list_step shall be ignored.
REQ-030 reg_num shall be combinational from the registered mask: priority-encode the lowest set bit; value 0 when the mask is empty.
REQ-031 An empty list (ir[15:0]=0) shall load list_count=0 and list_empty=1.
REQ-032 The list logic and the state/wait logic shall operate independently, and both shall update in the same cycle without interaction.

Reset
REQ-033 While reset=1 at a clock edge: state=RESET_STATE, wait counter=0, mask=0, list_count=0, mem_fault=0.
REQ-034 Reset shall take priority over moc, mem_wait, list_load and list_step, including in the middle of a wait or a list iteration.
REQ-035 After reset: list_empty=1, list_last=0, reg_num=0.

Structure
REQ-036 STATE_W, RESET_STATE, FAULT_STATE and the state-number constants shall be defined in the shared control package, which is also used by the next-state decoder.
REQ-037 The register-list iterator (mask, popcount, priority encoder, count) shall be one sub-module, reglist_iter.
REQ-038 The state register and wait counter shall be implemented in the top level; there shall be no combinational path from next_state to state.

Verification
REQ-039 Reset, then next_state=5 with mem_wait=0 -> state=0 during reset, then state=5 one edge after reset is released.
REQ-040 state=3, mem_wait=1, moc=0 for 4 cycles, then moc=1 with next_state=4 -> state holds at 3 for 4 cycles, then becomes 4, and the counter is 0.
REQ-041 mem_wait=1, moc=0 for 16 cycles -> state=1 on the 16th edge, mem_fault high for exactly 1 cycle; the same scenario with moc=1 on cycle 16 -> no fault and state=next_state.
REQ-042 list_load with ir[15:0]=16'h8005, then 3 list_step pulses -> reg_num sequence 0, 2, 15; list_count 3, 2, 1, 0; list_last high only at count 1; a 4th list_step leaves count at 0.
REQ-043 list_load with ir[15:0]=0 -> list_empty=1 and reg_num=0; list_load and list_step together with 16'hFFFF -> list_count=16.
REQ-044 reset asserted in the middle of a wait and a list iteration (count 2) -> state=0, list_count=0, no mem_fault pulse.
